// File: rtl/note_pkg.sv
// Shared note types and helpers for the note history / display producer.
package note_pkg;

  localparam int unsigned NOTE_W = 6;

  typedef logic [NOTE_W-1:0] note_t;

  localparam note_t NOTE_NONE = '0;

  // Stability filter phases: IDLE (cnt=0), COUNTING, LOCKED (cnt==STABLE_CNT)
  typedef enum logic [1:0] {
    FLT_IDLE     = 2'd0,
    FLT_COUNTING = 2'd1,
    FLT_LOCKED   = 2'd2
  } flt_state_e;

  // A note code is meaningful unless it is silence
  function automatic logic note_is_valid(input note_t n);
    return n != NOTE_NONE;
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Upcoming-note FIFO. Power-of-two depth, registered full flag, and a
// look-ahead head (head after this cycle's push/pop) for same-cycle publication.
module note_fifo
  import note_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  note_t                  push_data_i,
  input  logic                   pop_i,
  output note_t                  head_o,
  output note_t                  head_next_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  note_t         mem_q [DEPTH];
  logic          push_ok, pop_ok;

  // Pointer/count next state; a push while full is dropped
  always_comb begin
    push_ok  = push_i && !full_q;
    pop_ok   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == (AW+1)'(DEPTH));
  end

  // Head now and head after this cycle; the second forwards a push that
  // lands straight in the head slot (push into empty, or push+pop at count 1)
  always_comb begin
    head_o      = (count_q == '0) ? NOTE_NONE : mem_q[rd_ptr_q];
    head_next_o = NOTE_NONE;
    if (count_d != '0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) head_next_o = push_data_i;
      else                                   head_next_o = mem_q[rd_ptr_d];
    end
  end

  // Pointer, count and full-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage write; contents are masked by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/note_history.sv
// Note history producer: stability filter on the raw note stream,
// past/current shadow history, upcoming-note FIFO, and publication.
// Build option NOTE_FRAME_SYNC_EN: publish only on frame_start; otherwise
// outputs follow the shadow values every cycle and frame_start is ignored.
module note_history
  import note_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  note_t note_in,
  input  logic  note_valid,
  input  note_t up_data,
  input  logic  up_valid,
  output logic  up_ready,
  input  logic  frame_start,
  output note_t past,
  output note_t current,
  output note_t future,
  output logic  match
);

  localparam logic [7:0] STABLE_C = 8'(STABLE_CNT);

  flt_state_e state_q, state_d;
  note_t      cand_q, cand_d;
  logic [7:0] cnt_q, cnt_d;
  logic       accept;

  note_t      sh_past_q, sh_past_d;
  note_t      sh_cur_q, sh_cur_d;
  note_t      past_q, cur_q, fut_q;
  logic       match_q;

  note_t                        fifo_head, fifo_head_next;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         fifo_full;
  logic                         pop;

  // Stability filter: acceptance fires once, on the sample where cnt reaches STABLE_CNT
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    accept  = 1'b0;
    if (note_valid) begin
      if (note_in != cand_q) begin
        cand_d  = note_in;
        cnt_d   = 8'd1;
        accept  = (STABLE_C == 8'd1);
        state_d = accept ? FLT_LOCKED : FLT_COUNTING;
      end else if (cnt_q < STABLE_C) begin
        cnt_d   = cnt_q + 8'd1;
        accept  = (cnt_d == STABLE_C);
        state_d = accept ? FLT_LOCKED : FLT_COUNTING;
      end
    end
  end

  // History update and FIFO pop on acceptance of a real, non-repeated note
  always_comb begin
    sh_past_d = sh_past_q;
    sh_cur_d  = sh_cur_q;
    pop       = accept && note_is_valid(note_in) &&
                (fifo_count != '0) && (note_in == fifo_head);
    if (accept && note_is_valid(note_in) && (note_in != sh_cur_q)) begin
      sh_past_d = sh_cur_q;
      sh_cur_d  = note_in;
    end
  end

  note_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (up_valid),
    .push_data_i (up_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .head_next_o (fifo_head_next),
    .count_o     (fifo_count),
    .full_o      (fifo_full)
  );

  // Filter and shadow registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FLT_IDLE;
      cand_q    <= NOTE_NONE;
      cnt_q     <= '0;
      sh_past_q <= NOTE_NONE;
      sh_cur_q  <= NOTE_NONE;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sh_past_q <= sh_past_d;
      sh_cur_q  <= sh_cur_d;
      match_q   <= pop;
    end
  end

  // Publication; uses next-state shadow values so a coincident acceptance
  // or pop is already visible in the published codes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      past_q <= NOTE_NONE;
      cur_q  <= NOTE_NONE;
      fut_q  <= NOTE_NONE;
    end else begin
`ifdef NOTE_FRAME_SYNC_EN
      if (frame_start) begin
        past_q <= sh_past_d;
        cur_q  <= sh_cur_d;
        fut_q  <= fifo_head_next;
      end
`else
      past_q <= sh_past_d;
      cur_q  <= sh_cur_d;
      fut_q  <= fifo_head_next;
`endif
    end
  end

`ifndef NOTE_FRAME_SYNC_EN
  // frame_start has no function in free-running publication
  logic unused_frame_start;
  assign unused_frame_start = frame_start;
`endif

  assign up_ready = !fifo_full;
  assign past     = past_q;
  assign current  = cur_q;
  assign future   = fut_q;
  assign match    = match_q;

endmodule

// File: tb/tb_note_history.sv
// Directed bench for note_history (STABLE_CNT=8, FIFO_DEPTH=4).
// Every check follows a frame_start pulse so it holds in either publication mode.
module tb_note_history;
  import note_pkg::*;

  logic  clk = 1'b0;
  logic  reset;
  note_t note_in;
  logic  note_valid;
  note_t up_data;
  logic  up_valid;
  logic  up_ready;
  logic  frame_start;
  note_t past, current, future;
  logic  match;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned match_seen;

  note_history #(.STABLE_CNT(8), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .note_in     (note_in),
    .note_valid  (note_valid),
    .up_data     (up_data),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .frame_start (frame_start),
    .past        (past),
    .current     (current),
    .future      (future),
    .match       (match)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid sample; optional coincident frame_start
  task automatic sample(input note_t n, input logic fs);
    note_in     = n;
    note_valid  = 1'b1;
    frame_start = fs;
    tick();
    if (match) match_seen++;
    note_valid  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic run(input note_t n, input int unsigned len);
    for (int unsigned i = 0; i < len; i++) sample(n, 1'b0);
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
  endtask

  task automatic push(input note_t d);
    up_data  = d;
    up_valid = 1'b1;
    tick();
    up_valid = 1'b0;
  endtask

  task automatic hist(input string tag, input note_t p, input note_t c);
    check({tag, ".past"}, 32'(past), 32'(p));
    check({tag, ".current"}, 32'(current), 32'(c));
  endtask

  initial begin
    reset = 1'b0; note_in = '0; note_valid = 1'b0;
    up_data = '0; up_valid = 1'b0; frame_start = 1'b0;
    match_seen = 0;
    #1;
    check("rst.past", 32'(past), 0);
    check("rst.current", 32'(current), 0);
    check("rst.future", 32'(future), 0);
    check("rst.match", 32'(match), 0);
    check("rst.up_ready", 32'(up_ready), 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // 7 samples are not enough; the 8th with frame_start publishes at once
    run(6'd5, 7);
    frame();
    hist("five7", 6'd0, 6'd0);
    sample(6'd5, 1'b1);
    hist("five8", 6'd0, 6'd5);

    // Second note shifts history; a long saturated run adds nothing
    run(6'd9, 8);
    frame();
    hist("nine", 6'd5, 6'd9);
    run(6'd9, 20);
    frame();
    hist("nine_sat", 6'd5, 6'd9);

    // Glitch restarts the candidate; 7 never accepted
    run(6'd5, 4);
    sample(6'd7, 1'b0);
    run(6'd5, 7);
    frame();
    hist("glitch7", 6'd5, 6'd9);
    sample(6'd5, 1'b0);
    frame();
    hist("glitch8", 6'd9, 6'd5);

    // Fill FIFO, drop the 5th push
    push(6'd12); push(6'd14); push(6'd3); push(6'd20);
    check("fifo.full_ready", 32'(up_ready), 0);
    push(6'd30);
    frame();
    check("fifo.future_head", 32'(future), 12);
    check("fifo.still_full", 32'(up_ready), 0);

    // Accept 12: match pulse on the edge after acceptance, post-pop head published
    run(6'd12, 7);
    check("m12.nomatch_early", 32'(match), 0);
    sample(6'd12, 1'b1);
    check("m12.match", 32'(match), 1);
    check("m12.future", 32'(future), 14);
    hist("m12", 6'd5, 6'd12);
    check("m12.up_ready", 32'(up_ready), 1);
    tick();
    check("m12.match_pulse", 32'(match), 0);

    // Drain; the dropped 30 must not appear
    run(6'd14, 8);
    frame();
    check("m14.future", 32'(future), 3);
    run(6'd3, 8);
    frame();
    check("m3.future", 32'(future), 20);
    run(6'd20, 8);
    frame();
    check("m20.future_empty", 32'(future), 0);
    hist("m20", 6'd3, 6'd20);
    check("m20.up_ready", 32'(up_ready), 1);

    // Silence run is accepted but leaves history alone
    match_seen = 0;
    run(6'd0, 8);
    frame();
    hist("silence", 6'd3, 6'd20);
    check("silence.match", match_seen, 0);

    // Reset mid-counting and with a queued push
    push(6'd11);
    run(6'd11, 4);
    reset = 1'b0;
    #1;
    check("mid_rst.past", 32'(past), 0);
    check("mid_rst.current", 32'(current), 0);
    check("mid_rst.future", 32'(future), 0);
    check("mid_rst.match", 32'(match), 0);
    check("mid_rst.up_ready", 32'(up_ready), 1);
    tick();
    reset = 1'b1;
    tick();
    match_seen = 0;
    run(6'd11, 7);
    frame();
    hist("post_rst7", 6'd0, 6'd0);
    sample(6'd11, 1'b1);
    hist("post_rst8", 6'd0, 6'd11);
    check("post_rst.future", 32'(future), 0);
    check("post_rst.match", match_seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/note_history.md
Name: note_history

Overview:
- Producer of the past/current/future note codes that the note display path renders.
- Filters the raw 6-bit note stream from the pitch detector with a stability counter and keeps a past/current history.
- Holds a small FIFO of upcoming expected notes and presents its head as "future".
- Publishes all three codes frame-synchronously so the display never tears mid-frame.

Parameters:
- STABLE_CNT, 8: consecutive identical valid samples required to accept a note (1..255).
- FIFO_DEPTH, 4: upcoming-note FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous reset, active-low
- note_in  input  6  raw detected note code; 0 = NOTE_NONE (silence)
- note_valid  input  1  one-cycle strobe, note_in sampled
- up_data  input  6  upcoming expected note to enqueue
- up_valid  input  1  enqueue request
- up_ready  output  1  FIFO not full
- frame_start  input  1  one-cycle pulse at start of vertical blank
- past  output  6  previously accepted note
- current  output  6  most recently accepted note
- future  output  6  FIFO head, NOTE_NONE when empty
- match  output  1  one-cycle pulse: accepted note equalled FIFO head (popped)

Behaviour:
- Reset (reset=0, async): past=current=future=0, match=0, up_ready=1, FIFO empty, filter cleared (cand=0, cnt=0), shadow regs 0.
- Stability filter, on note_valid only:
  - note_in != cand: cand<=note_in, cnt<=1.
  - Otherwise, if cnt<STABLE_CNT: cnt<=cnt+1.
  - Acceptance occurs on the sample where cnt reaches STABLE_CNT, and only once per run.
  - cnt saturates; no re-accept until cand changes.
  - STABLE_CNT=1: every changed sample is accepted.
- Acceptance of note N:
  - N==NOTE_NONE: ignored; history unchanged.
  - N==shadow current: ignored, repeated note.
  - Otherwise: shadow_past<=shadow_current, shadow_current<=N.
  - If the FIFO is non-empty and N==head: pop, match=1 the cycle after acceptance.
- FIFO:
  - Push when up_valid&&up_ready.
  - up_ready=0 when count==FIFO_DEPTH; a push while full is dropped.
  - Simultaneous push and pop while full: the pop frees a slot, but up_ready is registered (still 0), so the push is dropped.
  - Simultaneous push and pop while not full: count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
  - shadow_future = head, or 0 when empty.
- Publication: on frame_start, past/current/future<=shadow values (one-cycle latency).
  - If acceptance and frame_start coincide, the published values include that acceptance; the shadow is updated combinationally-forwarded.
  - If a pop and frame_start coincide, future reflects the post-pop head.
- No internal FSM beyond filter {IDLE(cnt=0), COUNTING, LOCKED(cnt==STABLE_CNT)}:
  - IDLE->COUNTING on first valid sample.
  - COUNTING->LOCKED at acceptance.
  - Any changed sample->COUNTING.
- Reset mid-operation: immediate clear; in-flight samples are lost.

Optional Feature:
- NOTE_FRAME_SYNC_EN defined: publication gated on frame_start as above.
- Undefined: outputs track the shadow registers one cycle after any update; frame_start is ignored.

Decomposition:
- Package note_pkg:
  - NOTE_W=6, NOTE_NONE=6'd0
  - typedef note_t (logic [NOTE_W-1:0])
  - function note_is_valid.
- Sub-module note_fifo (parameter DEPTH): push/pop, head, count, full/empty.
- Filter, history and publication stay in note_history.

Test Plan:
- Reset, STABLE_CNT=8: drive note_in=5 valid ×7 -> no change. 8th valid + frame_start -> current=5, past=0.
- Sequence 5(×8), 9(×8), frame_start -> past=5, current=9. Then 9 ×20 more -> no further change.
- Glitch: 5×4, 7×1, 5×8 -> cand restarts. current=5 is accepted only after the final 8. Note 7 is never accepted.
- FIFO: push 12,14,3,20 -> up_ready=0. 5th push dropped. Accept 12 -> match pulse, future=14 after frame_start.
- Silence: accepted NOTE_NONE run (0×8) -> past/current unchanged, match=0.
- Assert reset mid-COUNTING and mid-push -> all outputs 0 and up_ready=1 while reset=0. First note after release needs the full STABLE_CNT samples.
